// File: rtl/rle_pkg.sv
// Shared types for the run-length tokenizer: default run length width,
// token layout and tokenizer FSM states.
package rle_pkg;

  localparam int DEFAULT_LEN_W = 13;

  // Token layout {sof, eol, bit, len}; the top packs vectors in this order
  // so a LEN_W-parameterised instance keeps the same field ordering.
  typedef struct packed {
    logic                     sof;
    logic                     eol;
    logic                     value;
    logic [DEFAULT_LEN_W-1:0] len;
  } token_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

endpackage

// File: rtl/rle_token_fifo.sv
// Show-ahead token FIFO with registered storage and an occupancy level;
// full and empty are derived from the level, pointers wrap modulo DEPTH.
module rle_token_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (level != FULL_LVL);
  assign do_pop  = pop && (level != '0);
  assign valid   = (level != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/rle_run_tokenizer.sv
// Turns a 1-bit-per-pixel mask stream into {bit, len, sof, eol} run tokens
// and queues them in a show-ahead FIFO with valid/ready output.
module rle_run_tokenizer
  import rle_pkg::*;
#(
  parameter int LEN_W = DEFAULT_LEN_W,
  parameter int DEPTH = 8
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic                      in_bit,
  input  logic                      in_sof,
  input  logic                      in_eol,
  output logic                      in_ready,
  output logic                      tok_valid,
  input  logic                      tok_ready,
  output logic                      tok_bit,
  output logic [LEN_W-1:0]          tok_len,
  output logic                      tok_sof,
  output logic                      tok_eol,
  output logic [$clog2(DEPTH):0]    fifo_level
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int TOK_W = LEN_W + 3;
  localparam logic [LEN_W-1:0] MAX_LEN  = '1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  state_t           state, state_next;
  logic             run_bit, run_bit_next;
  logic             run_sof, run_sof_next;
  logic [LEN_W-1:0] count, count_next;
  logic [TOK_W-1:0] pend, pend_next;
  logic [TOK_W-1:0] push_data, head;
  logic             push, accept, close_old, start_new, fifo_room;

  assign fifo_room = (fifo_level < FULL_LVL);
  assign in_ready  = !reset && (state != FLUSH) && fifo_room;
  assign accept    = in_valid && in_ready;
  assign close_old = accept && (state == RUN) &&
                     ((in_bit != run_bit) || (count == MAX_LEN) || in_sof);
  assign start_new = (state != RUN) || close_old;

  // A mid-line sof closes the old run with eol set; an eol pixel that also
  // closed a run leaves its own token pending for FLUSH (one write per cycle).
  always_comb begin
    state_next   = state;
    run_bit_next = run_bit;
    run_sof_next = run_sof;
    count_next   = count;
    pend_next    = pend;
    push         = 1'b0;
    push_data    = '0;
    case (state)
      FLUSH: begin
        if (fifo_room) begin
          push       = 1'b1;
          push_data  = pend;
          state_next = IDLE;
        end
      end
      default: begin
        if (accept) begin
          run_bit_next = in_bit;
          run_sof_next = start_new ? in_sof : run_sof;
          count_next   = start_new ? LEN_W'(1) : count + 1'b1;
          state_next   = RUN;
          if (close_old) begin
            push      = 1'b1;
            push_data = {run_sof, in_sof, run_bit, count};
          end
          if (in_eol) begin
            if (close_old) begin
              pend_next  = {run_sof_next, 1'b1, in_bit, count_next};
              state_next = FLUSH;
            end else begin
              push       = 1'b1;
              push_data  = {run_sof_next, 1'b1, in_bit, count_next};
              state_next = IDLE;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state   <= IDLE;
      run_bit <= 1'b0;
      run_sof <= 1'b0;
      count   <= '0;
      pend    <= '0;
    end else begin
      state   <= state_next;
      run_bit <= run_bit_next;
      run_sof <= run_sof_next;
      count   <= count_next;
      pend    <= pend_next;
    end
  end

  rle_token_fifo #(
    .WIDTH(TOK_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .reset    (reset),
    .push     (push),
    .push_data(push_data),
    .pop      (tok_ready),
    .head     (head),
    .valid    (tok_valid),
    .level    (fifo_level)
  );

  assign {tok_sof, tok_eol, tok_bit, tok_len} = head;

endmodule

// File: tb/tb_rle_run_tokenizer.sv
// Directed bench for rle_run_tokenizer: a per-cycle vector table plus
// hand-written sequences for run splitting, backpressure and reset in FLUSH.
module tb_rle_run_tokenizer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_bit, in_sof, in_eol, in_ready;
  logic        tok_valid, tok_ready, tok_bit, tok_sof, tok_eol;
  logic [12:0] tok_len;
  logic [3:0]  fifo_level;

  logic        v4, b4, s4, e4, rdy4, tv4, r4, tb4, ts4, te4;
  logic [3:0]  tl4;
  logic [3:0]  lvl4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rle_run_tokenizer #(.LEN_W(13), .DEPTH(8)) dut (
    .CLK(clk), .reset(reset),
    .in_valid(in_valid), .in_bit(in_bit), .in_sof(in_sof), .in_eol(in_eol),
    .in_ready(in_ready), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_bit(tok_bit), .tok_len(tok_len), .tok_sof(tok_sof), .tok_eol(tok_eol),
    .fifo_level(fifo_level)
  );

  rle_run_tokenizer #(.LEN_W(4), .DEPTH(8)) dut4 (
    .CLK(clk), .reset(reset),
    .in_valid(v4), .in_bit(b4), .in_sof(s4), .in_eol(e4),
    .in_ready(rdy4), .tok_valid(tv4), .tok_ready(r4),
    .tok_bit(tb4), .tok_len(tl4), .tok_sof(ts4), .tok_eol(te4),
    .fifo_level(lvl4)
  );

  typedef struct {
    logic v, b, s, e, rdy;
    logic x_ready, x_valid, x_bit;
    int   x_len;
    logic x_sof, x_eol;
    int   x_level;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic v, b, s, e, rdy, xr, xv, xb,
                         input int xl, input logic xs, xe, input int xlev);
    vec_t t;
    t.v = v; t.b = b; t.s = s; t.e = e; t.rdy = rdy;
    t.x_ready = xr; t.x_valid = xv; t.x_bit = xb; t.x_len = xl;
    t.x_sof = xs; t.x_eol = xe; t.x_level = xlev;
    vecs.push_back(t);
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t t);
    in_valid  = t.v;
    in_bit    = t.b;
    in_sof    = t.s;
    in_eol    = t.e;
    tok_ready = t.rdy;
  endtask

  initial begin
    logic bitv, sofv, acc;
    int   guard;

    reset = 1'b1;
    in_valid = 0; in_bit = 0; in_sof = 0; in_eol = 0; tok_ready = 1;
    v4 = 0; b4 = 0; s4 = 0; e4 = 0; r4 = 0;

    // Line 1,1,1,0,0 with sof/eol
    add_vec(1,1,1,0,1, 1,0,0,0,0,0,0);
    add_vec(1,1,0,0,1, 1,0,0,0,0,0,0);
    add_vec(1,1,0,0,1, 1,0,0,0,0,0,0);
    add_vec(1,0,0,0,1, 1,0,0,0,0,0,0);
    add_vec(1,0,0,1,1, 1,1,1,3,1,0,1);
    add_vec(0,0,0,0,1, 1,1,0,2,0,1,1);
    add_vec(0,0,0,0,1, 1,0,0,0,0,0,0);
    // Alternating 1,0,1,0 with eol on last: one FLUSH cycle
    add_vec(1,1,0,0,1, 1,0,0,0,0,0,0);
    add_vec(1,0,0,0,1, 1,0,0,0,0,0,0);
    add_vec(1,1,0,0,1, 1,1,1,1,0,0,1);
    add_vec(1,0,0,1,1, 1,1,0,1,0,0,1);
    add_vec(0,0,0,0,1, 0,1,1,1,0,0,1);
    add_vec(0,0,0,0,1, 1,1,0,1,0,1,1);
    add_vec(0,0,0,0,1, 1,0,0,0,0,0,0);
    // 1,1 then 0 with mid-line sof, then 0 with eol
    add_vec(1,1,0,0,1, 1,0,0,0,0,0,0);
    add_vec(1,1,0,0,1, 1,0,0,0,0,0,0);
    add_vec(1,0,1,0,1, 1,0,0,0,0,0,0);
    add_vec(1,0,0,1,1, 1,1,1,2,0,1,1);
    add_vec(0,0,0,0,1, 1,1,0,2,1,1,1);
    add_vec(0,0,0,0,1, 1,0,0,0,0,0,0);

    @(negedge clk);
    @(negedge clk);
    #1 check_output("rst_in_ready_low", in_ready, 0);
    reset = 1'b0;
    #1;
    check_output("rst_tok_valid", tok_valid, 0);
    check_output("rst_level", fifo_level, 0);
    check_output("rst_in_ready_high", in_ready, 1);

    foreach (vecs[i]) begin
      @(negedge clk);
      apply_stimulus(vecs[i]);
      #1;
      check_output($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].x_ready);
      check_output($sformatf("vec%0d_tok_valid", i), tok_valid, vecs[i].x_valid);
      check_output($sformatf("vec%0d_level", i), fifo_level, vecs[i].x_level);
      if (vecs[i].x_valid) begin
        check_output($sformatf("vec%0d_bit", i), tok_bit, vecs[i].x_bit);
        check_output($sformatf("vec%0d_len", i), tok_len, vecs[i].x_len);
        check_output($sformatf("vec%0d_sof", i), tok_sof, vecs[i].x_sof);
        check_output($sformatf("vec%0d_eol", i), tok_eol, vecs[i].x_eol);
      end
    end

    // 20 ones on the LEN_W=4 instance split into 15 + 5
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      v4 = 1; b4 = 1; s4 = (k == 0); e4 = (k == 19);
      #1 check_output($sformatf("split_ready%0d", k), rdy4, 1);
    end
    @(negedge clk);
    v4 = 0; s4 = 0; e4 = 0;
    #1;
    check_output("split_level", lvl4, 2);
    check_output("split_valid0", tv4, 1);
    check_output("split_bit0", tb4, 1);
    check_output("split_len0", tl4, 15);
    check_output("split_sof0", ts4, 1);
    check_output("split_eol0", te4, 0);
    r4 = 1;
    @(negedge clk);
    #1;
    check_output("split_bit1", tb4, 1);
    check_output("split_len1", tl4, 5);
    check_output("split_sof1", ts4, 0);
    check_output("split_eol1", te4, 1);
    @(negedge clk);
    #1 check_output("split_empty", tv4, 0);

    // Backpressure: fill FIFO with alternating single-pixel runs
    tok_ready = 0;
    bitv = 1; sofv = 1; guard = 0;
    while (fifo_level != 8 && guard < 40) begin
      @(negedge clk);
      in_valid = 1; in_bit = bitv; in_sof = sofv; in_eol = 0;
      #1 acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        bitv = ~bitv;
        sofv = 0;
      end
      guard++;
    end
    check_output("full_level", fifo_level, 8);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check_output($sformatf("full_stall_ready%0d", k), in_ready, 0);
      check_output($sformatf("full_hold_level%0d", k), fifo_level, 8);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      in_valid = 0; tok_ready = 1;
      #1;
      check_output($sformatf("drain%0d_valid", k), tok_valid, 1);
      check_output($sformatf("drain%0d_bit", k), tok_bit, (k % 2 == 0) ? 1 : 0);
      check_output($sformatf("drain%0d_len", k), tok_len, 1);
      check_output($sformatf("drain%0d_sof", k), tok_sof, (k == 0) ? 1 : 0);
      check_output($sformatf("drain%0d_eol", k), tok_eol, 0);
    end
    @(negedge clk);
    #1 check_output("drain_empty", tok_valid, 0);

    @(negedge clk);
    reset = 1; in_valid = 0; tok_ready = 0;
    @(negedge clk);
    reset = 0;

    // Reset while in FLUSH with three tokens queued
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1; in_bit = (k % 2 == 0); in_sof = 0; in_eol = (k == 3);
    end
    @(negedge clk);
    in_valid = 0; in_eol = 0;
    #1;
    check_output("flush_in_ready", in_ready, 0);
    check_output("flush_level", fifo_level, 3);
    reset = 1;
    @(negedge clk);
    reset = 0;
    #1;
    check_output("post_rst_valid", tok_valid, 0);
    check_output("post_rst_level", fifo_level, 0);
    check_output("post_rst_in_ready", in_ready, 1);
    tok_ready = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1 check_output($sformatf("no_stale%0d", k), tok_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
